// File: rtl/bsr_chain_router_if.sv
// Bundle of TAP-side and chain-side signals for the boundary-scan chain router.
// master = TAP controller plus the chains; slave = the router itself.
interface bsr_chain_router_if #(
  parameter int CHAIN_NUM = 4,
  parameter int SEL_WIDTH = $clog2(CHAIN_NUM)
);
  logic                 tdi;
  logic                 shift_dr;
  logic                 capture_dr;
  logic                 update_dr;
  logic                 sel_shift;
  logic                 sel_update;
  logic [CHAIN_NUM-1:0] bsr_so;
  logic [CHAIN_NUM-1:0] bsr_si;
  logic [CHAIN_NUM-1:0] bsr_shift;
  logic [CHAIN_NUM-1:0] bsr_capture;
  logic [CHAIN_NUM-1:0] bsr_update;
  logic                 tdo;
  logic [SEL_WIDTH-1:0] sel_active;
  logic                 mode_active;
  logic                 sel_err;

  modport master (
    output tdi, shift_dr, capture_dr, update_dr, sel_shift, sel_update, bsr_so,
    input  bsr_si, bsr_shift, bsr_capture, bsr_update, tdo, sel_active,
           mode_active, sel_err
  );

  modport slave (
    input  tdi, shift_dr, capture_dr, update_dr, sel_shift, sel_update, bsr_so,
    output bsr_si, bsr_shift, bsr_capture, bsr_update, tdo, sel_active,
           mode_active, sel_err
  );
endinterface

// File: rtl/bsr_chain_router.sv
// Boundary-scan chain router: routes TDI/TDO between a TAP and CHAIN_NUM chains,
// either one selected chain or all chains concatenated, selected through a
// serially loaded shadow register that is committed on sel_update.
module bsr_chain_router #(
  parameter int CHAIN_NUM = 4,
  parameter int SEL_WIDTH = $clog2(CHAIN_NUM),
  parameter int SW        = SEL_WIDTH + 1
) (
  input logic               tck,
  input logic               trst_n,
  bsr_chain_router_if.slave bus
);

  // Chain count widened by one bit so the range check can never overflow.
  localparam logic [SEL_WIDTH:0] ChainCount = (SEL_WIDTH + 1)'(CHAIN_NUM);

  logic [SW-1:0]        shadow_q, shadow_d;
  logic [SEL_WIDTH-1:0] selActive_q, selActive_d;
  logic                 modeActive_q, modeActive_d;
  logic                 selErr_q, selErr_d;
  logic                 tdo_q, tdo_d;

  logic                 shadowValid;
  logic                 tdoSrc;
  logic [CHAIN_NUM-1:0] siVec;
  logic [CHAIN_NUM-1:0] shiftVec;
  logic [CHAIN_NUM-1:0] captureVec;
  logic [CHAIN_NUM-1:0] updateVec;

  // Shadow shift, select commit with range check, and TDO source choice.
  always_comb begin
    shadow_d     = shadow_q;
    selActive_d  = selActive_q;
    modeActive_d = modeActive_q;
    selErr_d     = selErr_q;
    tdo_d        = tdo_q;
    shadowValid  = shadow_q[SW-1] | ({1'b0, shadow_q[SEL_WIDTH-1:0]} < ChainCount);

    if (bus.sel_shift) begin
      shadow_d = {bus.tdi, shadow_q[SW-1:1]};
    end

    if (bus.sel_update) begin
      if (shadowValid) begin
        selActive_d  = shadow_q[SEL_WIDTH-1:0];
        modeActive_d = shadow_q[SW-1];
        selErr_d     = 1'b0;
      end else begin
        selErr_d = 1'b1;
      end
    end

    if (bus.sel_shift) begin
      tdo_d = shadow_q[0];
    end else if (bus.shift_dr) begin
      tdo_d = tdoSrc;
    end
  end

  // State registers, cleared asynchronously by trst_n.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      shadow_q     <= '0;
      selActive_q  <= '0;
      modeActive_q <= 1'b0;
      selErr_q     <= 1'b0;
      tdo_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      selActive_q  <= selActive_d;
      modeActive_q <= modeActive_d;
      selErr_q     <= selErr_d;
      tdo_q        <= tdo_d;
    end
  end

  // Per-chain data and strobe routing; a select-register shift silences all strobes.
  always_comb begin
    siVec      = '0;
    shiftVec   = '0;
    captureVec = '0;
    updateVec  = '0;
    tdoSrc     = 1'b0;

    if (modeActive_q) begin
      siVec[0] = bus.tdi;
      for (int i = 1; i < CHAIN_NUM; i++) begin
        siVec[i] = bus.bsr_so[i-1];
      end
      shiftVec   = {CHAIN_NUM{bus.shift_dr}};
      captureVec = {CHAIN_NUM{bus.capture_dr}};
      updateVec  = {CHAIN_NUM{bus.update_dr}};
      tdoSrc     = bus.bsr_so[CHAIN_NUM-1];
    end else begin
      for (int i = 0; i < CHAIN_NUM; i++) begin
        if (selActive_q == SEL_WIDTH'(i)) begin
          siVec[i]      = bus.tdi;
          shiftVec[i]   = bus.shift_dr;
          captureVec[i] = bus.capture_dr;
          updateVec[i]  = bus.update_dr;
          tdoSrc        = bus.bsr_so[i];
        end
      end
    end

    if (bus.sel_shift) begin
      shiftVec   = '0;
      captureVec = '0;
      updateVec  = '0;
    end
  end

  assign bus.bsr_si      = siVec;
  assign bus.bsr_shift   = shiftVec;
  assign bus.bsr_capture = captureVec;
  assign bus.bsr_update  = updateVec;
  assign bus.tdo         = tdo_q;
  assign bus.sel_active  = selActive_q;
  assign bus.mode_active = modeActive_q;
  assign bus.sel_err     = selErr_q;

endmodule

// File: tb/tb_bsr_chain_router.sv
// Testbench for bsr_chain_router: a 4-chain instance with 1-bit stub chains and
// a 3-chain instance for out-of-range select handling.
module tb_bsr_chain_router;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic expQ[$];
  logic [2:0] shadowModel = 3'b000;
  logic [3:0] chainQ;

  always #5 tck = ~tck;

  bsr_chain_router_if #(.CHAIN_NUM(4)) b4 ();
  bsr_chain_router_if #(.CHAIN_NUM(3)) b3 ();

  bsr_chain_router #(.CHAIN_NUM(4)) dut4 (.tck(tck), .trst_n(trst_n), .bus(b4.slave));
  bsr_chain_router #(.CHAIN_NUM(3)) dut3 (.tck(tck), .trst_n(trst_n), .bus(b3.slave));

  // One-bit stub chains behind the 4-chain instance.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      chainQ <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (b4.bsr_shift[i]) chainQ[i] <= b4.bsr_si[i];
      end
    end
  end

  assign b4.bsr_so = chainQ;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic applyStimulus4(input logic [2:0] word);
    for (int i = 0; i < 3; i++) begin
      b4.tdi = word[i];
      b4.sel_shift = 1'b1;
      shadowModel = {word[i], shadowModel[2:1]};
      tick();
    end
    b4.sel_shift = 1'b0;
    b4.tdi = 1'b0;
  endtask

  task automatic update4();
    b4.sel_update = 1'b1;
    tick();
    b4.sel_update = 1'b0;
  endtask

  task automatic applyStimulus3(input logic [2:0] word);
    for (int i = 0; i < 3; i++) begin
      b3.tdi = word[i];
      b3.sel_shift = 1'b1;
      tick();
    end
    b3.sel_shift = 1'b0;
    b3.tdi = 1'b0;
    b3.sel_update = 1'b1;
    tick();
    b3.sel_update = 1'b0;
  endtask

  // Streams a pattern through tdi and scoreboards tdo after 'lat' cycles.
  task automatic runPattern(input string tag, input int lat, input logic [15:0] pat, input int n);
    logic expBit;
    b4.shift_dr = 1'b1;
    for (int k = 0; k < n + lat; k++) begin
      if (k < n) begin
        b4.tdi = pat[k];
        expQ.push_back(pat[k]);
      end else begin
        b4.tdi = 1'b0;
      end
      #1;
      if (k >= lat) begin
        expBit = expQ.pop_front();
        checkOutput(tag, 32'(b4.tdo), 32'(expBit));
      end
      tick();
    end
    b4.shift_dr = 1'b0;
    b4.tdi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expBit;
    {b4.tdi, b4.shift_dr, b4.capture_dr, b4.update_dr, b4.sel_shift, b4.sel_update} = '0;
    {b3.tdi, b3.shift_dr, b3.capture_dr, b3.update_dr, b3.sel_shift, b3.sel_update} = '0;
    b3.bsr_so = 3'b101;
    #12;
    trst_n = 1'b1;
    tick();

    // Reset state and default chain 0 routing.
    checkOutput("rst_sel", 32'(b4.sel_active), 32'd0);
    checkOutput("rst_mode", 32'(b4.mode_active), 32'd0);
    checkOutput("rst_err", 32'(b4.sel_err), 32'd0);
    checkOutput("rst_tdo", 32'(b4.tdo), 32'd0);
    b4.shift_dr = 1'b1;
    #1;
    checkOutput("rst_shift", 32'(b4.bsr_shift), 32'h1);
    b4.shift_dr = 1'b0;
    tick();

    // Select chain 2 in single-chain mode.
    applyStimulus4(3'b010);
    b4.sel_update = 1'b1;
    #1;
    checkOutput("sel_before_upd", 32'(b4.sel_active), 32'd0);
    tick();
    b4.sel_update = 1'b0;
    checkOutput("sel2_sel", 32'(b4.sel_active), 32'd2);
    checkOutput("sel2_mode", 32'(b4.mode_active), 32'd0);
    b4.shift_dr = 1'b1;
    b4.tdi = 1'b1;
    #1;
    checkOutput("sel2_shift", 32'(b4.bsr_shift), 32'h4);
    checkOutput("sel2_si1", 32'(b4.bsr_si), 32'h4);
    b4.tdi = 1'b0;
    #1;
    checkOutput("sel2_si0", 32'(b4.bsr_si), 32'h0);
    b4.shift_dr = 1'b0;
    b4.capture_dr = 1'b1;
    #1;
    checkOutput("sel2_capture", 32'(b4.bsr_capture), 32'h4);
    b4.capture_dr = 1'b0;
    tick();
    runPattern("sel2_tdo", 2, 16'hB5A3, 12);

    // Concatenate all chains.
    applyStimulus4(3'b100);
    update4();
    checkOutput("cat_mode", 32'(b4.mode_active), 32'd1);
    b4.shift_dr = 1'b1;
    #1;
    checkOutput("cat_shift", 32'(b4.bsr_shift), 32'hF);
    b4.update_dr = 1'b1;
    #1;
    checkOutput("cat_update", 32'(b4.bsr_update), 32'hF);
    b4.update_dr = 1'b0;
    b4.shift_dr = 1'b0;
    tick();
    runPattern("cat_tdo", 5, 16'h6D39, 14);

    // Select register readback while all strobes are requested.
    applyStimulus4(3'b101);
    b4.shift_dr = 1'b1;
    b4.capture_dr = 1'b1;
    b4.update_dr = 1'b1;
    b4.sel_shift = 1'b1;
    b4.tdi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(shadowModel[0]);
      shadowModel = {1'b0, shadowModel[2:1]};
      #1;
      checkOutput("rb_strobes", 32'({b4.bsr_shift, b4.bsr_capture, b4.bsr_update}), 32'h0);
      tick();
      expBit = expQ.pop_front();
      checkOutput("rb_tdo", 32'(b4.tdo), 32'(expBit));
    end
    {b4.shift_dr, b4.capture_dr, b4.update_dr, b4.sel_shift} = '0;

    // Simultaneous update and shift: commit the pre-shift shadow.
    applyStimulus4(3'b011);
    b4.sel_shift = 1'b1;
    b4.sel_update = 1'b1;
    b4.tdi = 1'b1;
    shadowModel = {1'b1, shadowModel[2:1]};
    tick();
    b4.sel_shift = 1'b0;
    b4.sel_update = 1'b0;
    b4.tdi = 1'b0;
    checkOutput("sim_sel", 32'(b4.sel_active), 32'd3);
    checkOutput("sim_mode", 32'(b4.mode_active), 32'd0);
    update4();
    checkOutput("sim_shadow_sel", 32'(b4.sel_active), 32'(shadowModel[1:0]));
    checkOutput("sim_shadow_mode", 32'(b4.mode_active), 32'(shadowModel[2]));

    // Reset asserted in the middle of a select shift.
    b4.sel_shift = 1'b1;
    b4.tdi = 1'b1;
    expBit = shadowModel[0];
    tick();
    checkOutput("pre_rst_tdo", 32'(b4.tdo), 32'(expBit));
    #2;
    trst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sel", 32'(b4.sel_active), 32'd0);
    checkOutput("mid_rst_mode", 32'(b4.mode_active), 32'd0);
    checkOutput("mid_rst_tdo", 32'(b4.tdo), 32'd0);
    b4.sel_shift = 1'b0;
    b4.tdi = 1'b0;
    #1;
    trst_n = 1'b1;
    shadowModel = 3'b000;
    tick();
    update4();
    checkOutput("post_rst_mode", 32'(b4.mode_active), 32'd0);
    checkOutput("post_rst_sel", 32'(b4.sel_active), 32'd0);

    // Out-of-range index handling on the 3-chain instance.
    applyStimulus3(3'b010);
    checkOutput("r3_sel2", 32'(b3.sel_active), 32'd2);
    checkOutput("r3_err0", 32'(b3.sel_err), 32'd0);
    applyStimulus3(3'b011);
    checkOutput("r3_bad_err", 32'(b3.sel_err), 32'd1);
    checkOutput("r3_bad_sel", 32'(b3.sel_active), 32'd2);
    b3.shift_dr = 1'b1;
    tick();
    b3.shift_dr = 1'b0;
    checkOutput("r3_tdo2", 32'(b3.tdo), 32'd1);
    applyStimulus3(3'b001);
    checkOutput("r3_ok_err", 32'(b3.sel_err), 32'd0);
    checkOutput("r3_ok_sel", 32'(b3.sel_active), 32'd1);
    b3.shift_dr = 1'b1;
    #1;
    checkOutput("r3_shift1", 32'(b3.bsr_shift), 32'h2);
    tick();
    b3.shift_dr = 1'b0;
    checkOutput("r3_tdo1", 32'(b3.tdo), 32'd0);
    applyStimulus3(3'b111);
    checkOutput("r3_cat_err", 32'(b3.sel_err), 32'd0);
    checkOutput("r3_cat_mode", 32'(b3.mode_active), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsr_chain_router.md
Name: bsr_chain_router

Overview:
Parametrised successor to the boundary-scan output mux. It routes TDI/TDO between a TAP and CHAIN_NUM boundary-scan chains. Chain selection sits in a serially loadable select register with a shadow/update scheme. Two modes are supported: single-chain select, or concatenation of all chains. The block gates per-chain shift/capture/update strobes and drives a registered TDO. It sits between the TAP controller and the BSR chains.

Parameters:
CHAIN_NUM, 4, number of boundary-scan chains (>=2).
SEL_WIDTH, $clog2(CHAIN_NUM), width of the chain-index field.
SW, SEL_WIDTH+1, select register width; bit SW-1 = mode, bits SEL_WIDTH-1:0 = index.

Ports:
tck  in  1  scan clock; all state on rising edge.
trst_n  in  1  asynchronous active-low reset.
tdi  in  1  serial data from TAP.
shift_dr  in  1  TAP Shift-DR with BSR instruction active.
capture_dr  in  1  TAP Capture-DR strobe.
update_dr  in  1  TAP Update-DR strobe.
sel_shift  in  1  TAP Shift-DR with CHAIN_SEL instruction active.
sel_update  in  1  TAP Update-DR with CHAIN_SEL instruction active.
bsr_so  in  CHAIN_NUM  serial out of each chain.
bsr_si  out  CHAIN_NUM  serial in to each chain.
bsr_shift  out  CHAIN_NUM  per-chain shift enable.
bsr_capture  out  CHAIN_NUM  per-chain capture enable.
bsr_update  out  CHAIN_NUM  per-chain update enable.
tdo  out  1  registered serial out to TAP.
sel_active  out  SEL_WIDTH  active chain index.
mode_active  out  1  0 = single chain, 1 = concatenate all.
sel_err  out  1  sticky: last sel_update carried an out-of-range index.

Behaviour:
- Reset (trst_n low, asynchronous, any time including mid-shift) clears all state:
  - shadow = 0, sel_active = 0, mode_active = 0, sel_err = 0, tdo = 0.
  - Combinational outputs follow from the reset state.
- Shadow register (SW bits):
  - When sel_shift = 1: shadow <= {tdi, shadow[SW-1:1]}. Loading is LSB first; SW clocks load a full word.
  - Otherwise the shadow holds.
- Update (sel_update = 1):
  - If shadow index < CHAIN_NUM, or shadow mode bit = 1: load sel_active/mode_active from shadow and clear sel_err.
  - Otherwise: active state is unchanged and sel_err <= 1.
  - The index is ignored when mode = 1.
- sel_update and sel_shift in the same cycle: update uses the pre-shift shadow value, and the shift also occurs.
- Per-chain routing is combinational from the active state.
  - Mode 0:
    - bsr_si[sel_active] = tdi; all other bsr_si = 0.
    - bsr_shift/capture/update[i] = shift_dr/capture_dr/update_dr & (i == sel_active).
    - TDO source = bsr_so[sel_active].
  - Mode 1:
    - bsr_si[0] = tdi; bsr_si[i] = bsr_so[i-1] for i > 0.
    - All strobes broadcast to every chain.
    - TDO source = bsr_so[CHAIN_NUM-1].
- When sel_shift = 1, all bsr_shift/capture/update are forced to 0. The CHAIN_SEL instruction excludes the BSR instruction.
- tdo register:
  - If sel_shift: tdo <= shadow[0] (pre-shift value).
  - Else if shift_dr: tdo <= chain TDO source.
  - Else: tdo holds.
  - Latency is 1 tck from source to tdo.
- sel_shift and shift_dr both high: sel_shift takes priority for tdo and strobe gating.
- A select change takes effect on the cycle after sel_update. Strobes never reach two chains in mode 0.

Test Plan:
- Reset: assert trst_n=0 mid-cycle -> immediately sel_active=0, mode_active=0, sel_err=0, tdo=0. Then shift_dr=1 -> bsr_shift=4'b0001.
- Select chain 2 (CHAIN_NUM=4, SW=3): sel_shift with tdi 0,1,0, then sel_update -> next cycle sel_active=2, mode_active=0. shift_dr=1 -> bsr_shift=4'b0100, bsr_si[2]=tdi, tdo follows bsr_so[2] one cycle later.
- Concatenate mode: shift word 3'b100, update -> mode_active=1, bsr_shift=4'b1111. Drive tdi pattern through stub chains of length 1 -> pattern appears on tdo after 4+1 cycles.
- Out-of-range (CHAIN_NUM=3): shift index 3, mode 0, update -> sel_err=1, sel_active unchanged. Then a valid index 1 with update -> sel_err=0, sel_active=1.
- Select readback: shadow=3'b101, sel_shift for 3 cycles with tdi=0 -> tdo sequence 1,0,1 (1-cycle latency). bsr_* strobes stay 0 throughout.
- Simultaneous: sel_update and sel_shift in the same cycle -> active loads the pre-shift shadow and the shadow shifts. Reset asserted mid-shift restores the all-zero state.
